mem_arbiter: RTL and testbench

Shares one single-port unified memory between the core's instruction-fetch port and its data port. It sits between the pipeline top and the memory. On either side it presents the same ce/addr/data interface the core already drives. Toward the memory it runs a req/ack handshake. It returns per-port stall signals that the core uses to freeze the whole pipeline. Data accesses have priority, and a bounded anti-starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and data ports.
// Data has priority; a bounded starvation counter forces a fetch grant.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_ce_i,
   input  logic [ADDR_WIDTH-1:0] inst_addr_i,
   output logic [DATA_WIDTH-1:0] inst_o,
   output logic                  inst_stall_o,
   input  logic                  data_ce_i,
   input  logic                  data_we_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  data_stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ack_i
);
   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   state_t     r_state, w_next;
   logic [3:0] r_starve;
   logic       w_force, w_gnt_d, w_gnt_i;

   always_comb begin
      w_force = inst_ce_i & data_ce_i & (STARVE_MAX != 0) & (r_starve == SMAX);
      w_gnt_d = (r_state == IDLE) & data_ce_i & ~w_force;
      w_gnt_i = (r_state == IDLE) & inst_ce_i & ~w_gnt_d;
      w_next  = r_state;
      case (r_state)
         IDLE:    w_next = w_gnt_d ? BUSY_D : w_gnt_i ? BUSY_I : IDLE;
         BUSY_I:  w_next = mem_ack_i ? RESP_I : BUSY_I;
         BUSY_D:  w_next = mem_ack_i ? RESP_D : BUSY_D;
         default: w_next = IDLE;
      endcase
   end

   assign inst_stall_o = inst_ce_i & (r_state != RESP_I);
   assign data_stall_o = data_ce_i & (r_state != RESP_D);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         inst_o      <= '0;
         data_o      <= '0;
         r_starve    <= '0;
      end else begin
         if (w_gnt_d | w_gnt_i) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= w_gnt_d & data_we_i;
            mem_addr_o <= w_gnt_d ? data_addr_i : inst_addr_i;
            if (w_gnt_d) mem_wdata_o <= data_i;
         end else if ((r_state == BUSY_I || r_state == BUSY_D) && mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (r_state == BUSY_I) inst_o <= mem_rdata_i;
            if (r_state == BUSY_D && !mem_we_o) data_o <= mem_rdata_i;
         end
         // counts data grants that bypassed a waiting fetch
         if (w_gnt_i || (r_state == IDLE && !inst_ce_i)) r_starve <= '0;
         else if (w_gnt_d && r_starve != 4'hF) r_starve <= r_starve + 4'd1;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven vectors plus multi-cycle sequences
// for starvation, async reset mid-transfer and flush mid-fetch.
module tb_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b0;
   logic        ic = 1'b0, dc = 1'b0, dwe = 1'b0, r_ack = 1'b0, auto_ack = 1'b0;
   logic [31:0] ia = '0, da = '0, dd = '0, rd = '0;
   logic [31:0] inst0, data0, addr0, wdata0, inst1, data1, addr1, wdata1;
   logic        ist0, dst0, req0, we0, ack0, ist1, dst1, req1, we1, ack1;
   int          checks = 0, errors = 0;

   typedef struct {
      logic        ic, dc, we, ack;
      logic [31:0] ia, da, wd, rd;
      logic        req, mwe, ist, dst;
      logic [31:0] addr, mwd, io, dout;
   } vec_t;
   vec_t v [17];

   always #5 clk = ~clk;
   assign ack0 = auto_ack ? req0 : r_ack;
   assign ack1 = req1;

   mem_arbiter #(.STARVE_MAX(2)) u0 (
      .clk(clk), .rst(rst), .inst_ce_i(ic), .inst_addr_i(ia), .inst_o(inst0),
      .inst_stall_o(ist0), .data_ce_i(dc), .data_we_i(dwe), .data_addr_i(da),
      .data_i(dd), .data_o(data0), .data_stall_o(dst0), .mem_req_o(req0),
      .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wdata0),
      .mem_rdata_i(rd), .mem_ack_i(ack0));

   mem_arbiter #(.STARVE_MAX(0)) u1 (
      .clk(clk), .rst(rst), .inst_ce_i(ic), .inst_addr_i(ia), .inst_o(inst1),
      .inst_stall_o(ist1), .data_ce_i(dc), .data_we_i(dwe), .data_addr_i(da),
      .data_i(dd), .data_o(data1), .data_stall_o(dst1), .mem_req_o(req1),
      .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wdata1),
      .mem_rdata_i(32'h0), .mem_ack_i(ack1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ic_, dc_, we_, ack_,
                               input logic [31:0] ia_, da_, wd_, rd_,
                               input logic req_, mwe_, ist_, dst_,
                               input logic [31:0] addr_, mwd_, io_, dout_);
      mk = '{ic_, dc_, we_, ack_, ia_, da_, wd_, rd_, req_, mwe_, ist_, dst_, addr_, mwd_, io_, dout_};
   endfunction

   task automatic do_reset();
      rst = 1'b0; ic = 1'b0; dc = 1'b0; dwe = 1'b0; r_ack = 1'b0; auto_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int ng, n1, f1;
      v[0]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h100,0,0,0,                  1'b0,1'b0,1'b1,1'b0, 32'h0,0,0,0);
      v[1]  = mk(1'b1,1'b0,1'b0,1'b1, 32'h100,0,0,32'h13,             1'b1,1'b0,1'b1,1'b0, 32'h100,0,0,0);
      v[2]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h100,0,0,0,                  1'b0,1'b0,1'b0,1'b0, 32'h100,0,32'h13,0);
      v[3]  = mk(1'b1,1'b1,1'b0,1'b0, 32'h104,32'h200,0,0,            1'b0,1'b0,1'b1,1'b1, 32'h100,0,32'h13,0);
      v[4]  = mk(1'b1,1'b1,1'b0,1'b1, 32'h104,32'h200,0,32'hCAFEF00D, 1'b1,1'b0,1'b1,1'b1, 32'h200,0,32'h13,0);
      v[5]  = mk(1'b1,1'b1,1'b0,1'b0, 32'h104,32'h200,0,0,            1'b0,1'b0,1'b1,1'b0, 32'h200,0,32'h13,32'hCAFEF00D);
      v[6]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h104,0,0,0,                  1'b0,1'b0,1'b1,1'b0, 32'h200,0,32'h13,32'hCAFEF00D);
      v[7]  = mk(1'b1,1'b0,1'b0,1'b1, 32'h104,0,0,32'h00A00093,       1'b1,1'b0,1'b1,1'b0, 32'h104,0,32'h13,32'hCAFEF00D);
      v[8]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h104,0,0,0,                  1'b0,1'b0,1'b0,1'b0, 32'h104,0,32'h00A00093,32'hCAFEF00D);
      v[9]  = mk(1'b0,1'b1,1'b1,1'b0, 0,32'h300,32'hDEADBEEF,0,       1'b0,1'b0,1'b0,1'b1, 32'h104,0,32'h00A00093,32'hCAFEF00D);
      v[10] = mk(1'b0,1'b1,1'b1,1'b0, 0,32'h3FC,32'h11111111,0,       1'b1,1'b1,1'b0,1'b1, 32'h300,32'hDEADBEEF,32'h00A00093,32'hCAFEF00D);
      v[11] = v[10];
      v[12] = v[10];
      v[13] = mk(1'b0,1'b1,1'b1,1'b1, 0,32'h3FC,32'h11111111,32'h55555555, 1'b1,1'b1,1'b0,1'b1, 32'h300,32'hDEADBEEF,32'h00A00093,32'hCAFEF00D);
      v[14] = mk(1'b0,1'b1,1'b1,1'b0, 0,32'h3FC,32'h11111111,0,       1'b0,1'b0,1'b0,1'b0, 32'h300,32'hDEADBEEF,32'h00A00093,32'hCAFEF00D);
      v[15] = mk(1'b0,1'b0,1'b0,1'b1, 0,0,0,32'h77777777,             1'b0,1'b0,1'b0,1'b0, 32'h300,32'hDEADBEEF,32'h00A00093,32'hCAFEF00D);
      v[16] = mk(1'b0,1'b0,1'b0,1'b0, 0,0,0,0,                        1'b0,1'b0,1'b0,1'b0, 32'h300,32'hDEADBEEF,32'h00A00093,32'hCAFEF00D);

      #12;
      chk("reset req", {31'b0, req0}, 32'h0);
      chk("reset we", {31'b0, we0}, 32'h0);
      chk("reset addr", addr0, 32'h0);
      chk("reset wdata", wdata0, 32'h0);
      chk("reset inst_o", inst0, 32'h0);
      chk("reset data_o", data0, 32'h0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 17; k++) begin
         ic = v[k].ic; dc = v[k].dc; dwe = v[k].we; r_ack = v[k].ack;
         ia = v[k].ia; da = v[k].da; dd = v[k].wd; rd = v[k].rd;
         @(negedge clk);
         chk($sformatf("v%0d req", k), {31'b0, req0}, {31'b0, v[k].req});
         chk($sformatf("v%0d mem_we", k), {31'b0, we0}, {31'b0, v[k].mwe});
         chk($sformatf("v%0d inst_stall", k), {31'b0, ist0}, {31'b0, v[k].ist});
         chk($sformatf("v%0d data_stall", k), {31'b0, dst0}, {31'b0, v[k].dst});
         chk($sformatf("v%0d addr", k), addr0, v[k].addr);
         chk($sformatf("v%0d wdata", k), wdata0, v[k].mwd);
         chk($sformatf("v%0d inst_o", k), inst0, v[k].io);
         chk($sformatf("v%0d data_o", k), data0, v[k].dout);
         @(posedge clk); #1;
      end

      // starvation: STARVE_MAX=2 gives D,D,I repeating; STARVE_MAX=0 never fetches
      do_reset();
      ia = 32'h400; da = 32'h500; dwe = 1'b0; ic = 1'b1; dc = 1'b1; auto_ack = 1'b1;
      ng = 0; n1 = 0; f1 = 0;
      for (int c = 0; c < 60 && ng < 9; c++) begin
         @(negedge clk);
         if (req0) begin
            chk($sformatf("starve grant %0d", ng), addr0, (ng % 3 == 2) ? 32'h400 : 32'h500);
            ng++;
         end
         if (req1) begin
            n1++;
            if (addr1 == 32'h400) f1++;
         end
      end
      chk("starve grant count", ng, 9);
      chk("pure priority fetch grants", f1, 0);
      chk("pure priority data grants", {31'b0, n1 >= 8}, 32'h1);

      // async reset in BUSY_D, then a pending fetch is granted
      do_reset();
      ic = 1'b1; ia = 32'h700; dc = 1'b1; da = 32'h600; dwe = 1'b1; dd = 32'hABCD0123;
      @(posedge clk); #1;
      chk("busy_d req", {31'b0, req0}, 32'h1);
      chk("busy_d addr", addr0, 32'h600);
      chk("busy_d we", {31'b0, we0}, 32'h1);
      chk("busy_d wdata", wdata0, 32'hABCD0123);
      #2 rst = 1'b0;
      #1;
      chk("async rst req", {31'b0, req0}, 32'h0);
      chk("async rst we", {31'b0, we0}, 32'h0);
      chk("async rst addr", addr0, 32'h0);
      chk("async rst wdata", wdata0, 32'h0);
      dc = 1'b0; dwe = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("post rst fetch req", {31'b0, req0}, 32'h1);
      chk("post rst fetch addr", addr0, 32'h700);
      chk("post rst fetch we", {31'b0, we0}, 32'h0);

      // flush mid-fetch: transfer completes, one RESP cycle, then IDLE
      ic = 1'b0; r_ack = 1'b1; rd = 32'h12345678;
      #1 chk("flush stall", {31'b0, ist0}, 32'h0);
      @(posedge clk); #1;
      chk("flush resp req", {31'b0, req0}, 32'h0);
      chk("flush inst_o", inst0, 32'h12345678);
      r_ack = 1'b0; ic = 1'b1; ia = 32'h704;
      #1 chk("resp_i stall", {31'b0, ist0}, 32'h0);
      @(posedge clk); #1;
      chk("no grant in resp", {31'b0, req0}, 32'h0);
      chk("idle stall", {31'b0, ist0}, 32'h1);
      @(posedge clk); #1;
      chk("regrant req", {31'b0, req0}, 32'h1);
      chk("regrant addr", addr0, 32'h704);
      r_ack = 1'b1;
      @(posedge clk); #1;
      r_ack = 1'b0; ic = 1'b0;
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
